// File: rtl/hazard_pkg.sv
// Shared types, forward-source codes and configuration checks for hazard_ctrl_mc.
package hazard_pkg;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpAlu   = 3'd1,
        OpLoad  = 3'd2,
        OpStore = 3'd3,
        OpMc    = 3'd4
    } optype_e;

    localparam logic [2:0] FWD_RF      = 3'd0;
    localparam logic [2:0] FWD_EXE     = 3'd1;
    localparam logic [2:0] FWD_MEM_ALU = 3'd2;
    localparam logic [2:0] FWD_MEM_LD  = 3'd3;
    localparam logic [2:0] FWD_WB      = 3'd4;

    // Raw class codes 5..7 are not instructions the controller cares about.
    function automatic optype_e decode_op(logic [2:0] raw);
        case (raw)
            3'd1:    return OpAlu;
            3'd2:    return OpLoad;
            3'd3:    return OpStore;
            3'd4:    return OpMc;
            default: return OpNone;
        endcase
    endfunction

    function automatic bit mc_cfg_ok(int unsigned cnt_w, int unsigned mc_lat);
        return (mc_lat >= 2) && (mc_lat <= 15) && ((64'd1 << cnt_w) > 64'(mc_lat));
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// ID-stage request and pipeline-control bundle; the pipeline is master, the controller slave.
interface hazard_ctrl_mc_if #(
    parameter int unsigned REG_AW = 5
);
    logic [2:0]        optype_ID;
    logic [REG_AW-1:0] rd_ID;
    logic [REG_AW-1:0] rs1_ID;
    logic [REG_AW-1:0] rs2_ID;
    logic              rs1use_ID;
    logic              rs2use_ID;
    logic              branch_ID;

    logic              PC_EN_IF;
    logic              reg_FD_EN;
    logic              reg_FD_flush;
    logic              reg_DE_EN;
    logic              reg_DE_flush;
    logic              reg_EM_flush;
    logic [2:0]        forward_ctrl_A;
    logic [2:0]        forward_ctrl_B;
    logic              forward_ctrl_ls;
    logic              mc_busy;

    modport master (
        output optype_ID, rd_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID, branch_ID,
        input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_flush,
        input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mc_busy
    );

    modport slave (
        input  optype_ID, rd_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID, branch_ID,
        output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_flush,
        output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mc_busy
    );
endinterface

// File: rtl/mc_busy_fsm.sv
// IDLE/BUSY occupancy tracker for a multi-cycle op in EXE; last_cycle flags the op's final,
// unheld EXE cycle.
module mc_busy_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic mc_busy,
    output logic last_cycle
);
    if (!mc_cfg_ok(CNT_W, MC_LAT)) begin : g_cfg_err
        $error("mc_busy_fsm: MC_LAT must be 2..15 and fit in CNT_W bits");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                    cnt_d   = CNT_W'(MC_LAT - 1);
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mc_busy    = (state_q == StBusy);
        last_cycle = done_q;
    end
endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller with private EXE/MEM/WB shadow pipeline and multi-cycle EXE ops.
// Define HAZARD_WB_FWD_EN to enable WB-stage operand forwarding (source code 4).
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MC_LAT = 3,
    parameter int unsigned CNT_W  = 4
) (
    input logic             clk,
    input logic             rst,
    hazard_ctrl_mc_if.slave bus
);
    typedef logic [REG_AW-1:0] reg_t;

    optype_e    id_op;
    optype_e    exe_op_q, exe_op_d, mem_op_q, mem_op_d;
    reg_t       exe_rd_q, exe_rd_d, exe_rs2_q, exe_rs2_d, mem_rd_q, mem_rd_d;
    logic       fsm_busy, last_cycle, mc_start;
    logic       rs1_dep, rs2_dep, rs1_hit_exe, rs2_hit_exe, load_use, mc_use, stall;
    logic [2:0] sel_a, sel_b;
`ifdef HAZARD_WB_FWD_EN
    optype_e    wb_op_q, wb_op_d;
    reg_t       wb_rd_q, wb_rd_d;
    logic       wb_src;
`endif

    // EXE and MEM sources; an MC op in EXE has no result yet and never forwards.
    function automatic logic [2:0] fwd_near(logic dep, reg_t rs, optype_e e_op, reg_t e_rd,
                                            optype_e m_op, reg_t m_rd);
        if (!dep) return FWD_RF;
        if (e_op == OpAlu && e_rd == rs) return FWD_EXE;
        if (m_op == OpAlu && m_rd == rs) return FWD_MEM_ALU;
        if (m_op == OpLoad && m_rd == rs) return FWD_MEM_LD;
        return FWD_RF;
    endfunction

    assign id_op = decode_op(bus.optype_ID);

    always_comb begin
        rs1_dep     = bus.rs1use_ID && (bus.rs1_ID != '0);
        rs2_dep     = bus.rs2use_ID && (bus.rs2_ID != '0);
        rs1_hit_exe = rs1_dep && (bus.rs1_ID == exe_rd_q);
        rs2_hit_exe = rs2_dep && (bus.rs2_ID == exe_rd_q);
        // A store depending on a load only through its data operand is served by forward_ctrl_ls.
        load_use    = (exe_op_q == OpLoad) &&
                      (rs1_hit_exe || (rs2_hit_exe && id_op != OpStore));
        mc_use      = last_cycle && (exe_op_q == OpMc) && (rs1_hit_exe || rs2_hit_exe);
        stall       = !fsm_busy && (load_use || mc_use);
        mc_start    = !fsm_busy && !stall && (id_op == OpMc);
    end

    mc_busy_fsm #(
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) u_mc_busy_fsm (
        .clk        (clk),
        .rst        (rst),
        .start      (mc_start),
        .mc_busy    (fsm_busy),
        .last_cycle (last_cycle)
    );

    always_comb begin
        exe_op_d  = exe_op_q;
        exe_rd_d  = exe_rd_q;
        exe_rs2_d = exe_rs2_q;
        mem_op_d  = OpNone;
        mem_rd_d  = '0;
        if (!fsm_busy) begin
            mem_rd_d = exe_rd_q;
            if (exe_op_q == OpMc) begin
                mem_op_d = OpAlu;
            end else begin
                mem_op_d = exe_op_q;
            end
            if (stall) begin
                exe_op_d  = OpNone;
                exe_rd_d  = '0;
                exe_rs2_d = '0;
            end else begin
                exe_op_d  = id_op;
                exe_rd_d  = bus.rd_ID;
                exe_rs2_d = bus.rs2_ID;
            end
        end
`ifdef HAZARD_WB_FWD_EN
        wb_op_d = mem_op_q;
        wb_rd_d = mem_rd_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_op_q  <= OpNone;
            exe_rd_q  <= '0;
            exe_rs2_q <= '0;
            mem_op_q  <= OpNone;
            mem_rd_q  <= '0;
        end else begin
            exe_op_q  <= exe_op_d;
            exe_rd_q  <= exe_rd_d;
            exe_rs2_q <= exe_rs2_d;
            mem_op_q  <= mem_op_d;
            mem_rd_q  <= mem_rd_d;
        end
    end

`ifdef HAZARD_WB_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_op_q <= OpNone;
            wb_rd_q <= '0;
        end else begin
            wb_op_q <= wb_op_d;
            wb_rd_q <= wb_rd_d;
        end
    end
`endif

    always_comb begin
        sel_a = fwd_near(rs1_dep, bus.rs1_ID, exe_op_q, exe_rd_q, mem_op_q, mem_rd_q);
        sel_b = fwd_near(rs2_dep, bus.rs2_ID, exe_op_q, exe_rd_q, mem_op_q, mem_rd_q);
`ifdef HAZARD_WB_FWD_EN
        wb_src = (wb_op_q == OpAlu) || (wb_op_q == OpLoad);
        if (sel_a == FWD_RF && rs1_dep && wb_src && wb_rd_q == bus.rs1_ID) sel_a = FWD_WB;
        if (sel_b == FWD_RF && rs2_dep && wb_src && wb_rd_q == bus.rs2_ID) sel_b = FWD_WB;
`endif
    end

    always_comb begin
        bus.PC_EN_IF     = 1'b1;
        bus.reg_FD_EN    = 1'b1;
        bus.reg_FD_flush = 1'b0;
        bus.reg_DE_EN    = 1'b1;
        bus.reg_DE_flush = 1'b0;
        bus.reg_EM_flush = 1'b0;
        if (fsm_busy) begin
            bus.PC_EN_IF     = 1'b0;
            bus.reg_FD_EN    = 1'b0;
            bus.reg_DE_EN    = 1'b0;
            bus.reg_EM_flush = 1'b1;
        end else if (stall) begin
            bus.PC_EN_IF     = 1'b0;
            bus.reg_FD_EN    = 1'b0;
            bus.reg_DE_flush = 1'b1;
        end else if (bus.branch_ID && !rst) begin
            bus.reg_FD_flush = 1'b1;
        end
        bus.forward_ctrl_A  = sel_a;
        bus.forward_ctrl_B  = sel_b;
        bus.forward_ctrl_ls = (exe_op_q == OpStore) && (mem_op_q == OpLoad) &&
                              (mem_rd_q != '0) && (exe_rs2_q == mem_rd_q);
        bus.mc_busy         = fsm_busy;
    end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed scenarios plus random traffic against an
// instruction-level pipeline model.
module tb_hazard_ctrl_mc;
    localparam int unsigned MC_LAT = 3;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] rd;
        logic [4:0] rs2;
    } ins_t;

    logic clk = 1'b0;
    logic rst;

    hazard_ctrl_mc_if #(.REG_AW(5)) bus ();

    hazard_ctrl_mc #(
        .REG_AW (5),
        .MC_LAT (MC_LAT),
        .CNT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    ins_t m_exe, m_mem, m_wb;
    int   mc_left;
    logic [2:0] s_fa, s_fb;
    logic s_pc, s_fden, s_fdf, s_deen, s_def, s_em, s_ls, s_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Operand source the model expects: nearest older instruction that has a result.
    function automatic int src(bit dep, logic [4:0] rs);
        if (!dep) return 0;
        if (m_exe.op == 3'd1 && m_exe.rd == rs) return 1;
        if ((m_mem.op == 3'd1 || m_mem.op == 3'd4) && m_mem.rd == rs) return 2;
        if (m_mem.op == 3'd2 && m_mem.rd == rs) return 3;
`ifdef HAZARD_WB_FWD_EN
        if ((m_wb.op == 3'd1 || m_wb.op == 3'd2 || m_wb.op == 3'd4) && m_wb.rd == rs) return 4;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_exe   = '0;
        m_mem   = '0;
        m_wb    = '0;
        mc_left = 0;
    endtask

    task automatic step(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2, input logic br);
        logic [2:0] idop;
        bit d1, d2, m1, m2, busy, fin, stl;
        bus.optype_ID = op;
        bus.rd_ID     = rd;
        bus.rs1_ID    = rs1;
        bus.rs2_ID    = rs2;
        bus.rs1use_ID = u1;
        bus.rs2use_ID = u2;
        bus.branch_ID = br;
        @(negedge clk);
        idop = (op > 3'd4) ? 3'd0 : op;
        busy = (m_exe.op == 3'd4) && (mc_left > 1);
        fin  = (m_exe.op == 3'd4) && (mc_left == 1);
        d1   = u1 && (rs1 != 0);
        d2   = u2 && (rs2 != 0);
        m1   = d1 && (rs1 == m_exe.rd);
        m2   = d2 && (rs2 == m_exe.rd);
        stl  = !busy && ((m_exe.op == 3'd2 && (m1 || (m2 && idop != 3'd3))) || (fin && (m1 || m2)));
        s_fa = bus.forward_ctrl_A;   s_fb = bus.forward_ctrl_B;
        s_pc = bus.PC_EN_IF;         s_fden = bus.reg_FD_EN;    s_fdf = bus.reg_FD_flush;
        s_deen = bus.reg_DE_EN;      s_def = bus.reg_DE_flush;  s_em = bus.reg_EM_flush;
        s_ls = bus.forward_ctrl_ls;  s_busy = bus.mc_busy;
        check("pc_en", 32'(s_pc), 32'(!(busy || stl)));
        check("fd_en", 32'(s_fden), 32'(!(busy || stl)));
        check("fd_flush", 32'(s_fdf), 32'(!busy && !stl && br));
        check("de_en", 32'(s_deen), 32'(!busy));
        check("de_flush", 32'(s_def), 32'(stl));
        check("em_flush", 32'(s_em), 32'(busy));
        check("mc_busy", 32'(s_busy), 32'(busy));
        check("fwd_a", 32'(s_fa), 32'(src(d1, rs1)));
        check("fwd_b", 32'(s_fb), 32'(src(d2, rs2)));
        check("fwd_ls", 32'(s_ls), 32'(m_exe.op == 3'd3 && m_mem.op == 3'd2 && m_mem.rd != 0 &&
                                       m_exe.rs2 == m_mem.rd));
        @(posedge clk);
        m_wb = m_mem;
        if (busy) begin
            m_mem = '0;
            mc_left--;
        end else begin
            m_mem   = m_exe;
            m_exe   = stl ? '0 : {idop, rd, rs2};
            mc_left = (m_exe.op == 3'd4) ? int'(MC_LAT) : 0;
        end
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc_en"}, 32'(bus.PC_EN_IF), 32'd1);
        check({tag, "_fd_en"}, 32'(bus.reg_FD_EN), 32'd1);
        check({tag, "_de_en"}, 32'(bus.reg_DE_EN), 32'd1);
        check({tag, "_flushes"}, 32'({bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush}), 32'd0);
        check({tag, "_fwd"}, 32'({bus.forward_ctrl_A, bus.forward_ctrl_B, bus.forward_ctrl_ls}), 32'd0);
        check({tag, "_busy"}, 32'(bus.mc_busy), 32'd0);
    endtask

    task automatic apply_reset();
        bus.optype_ID = 3'd0; bus.rd_ID = '0; bus.rs1_ID = '0; bus.rs2_ID = '0;
        bus.rs1use_ID = 1'b1; bus.rs2use_ID = 1'b1; bus.branch_ID = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        bus.rs1use_ID = 1'b0; bus.rs2use_ID = 1'b0; bus.branch_ID = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #1;
        apply_reset();

        // ALU -> ALU: EXE forward, then MEM forward across an independent instruction.
        step(3'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
        check("dir_fwd_exe", 32'(s_fa), 32'd1);
        nops(3);
        step(3'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b0);
        step(3'd1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
        check("dir_fwd_mem", 32'(s_fa), 32'd2);

        // Load-use stall, then load data from MEM on both operands.
        nops(3);
        step(3'd2, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
        check("dir_lu_pc", 32'(s_pc), 32'd0);
        check("dir_lu_deflush", 32'(s_def), 32'd1);
        step(3'd1, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
        check("dir_lu_fwd", 32'({s_fa, s_fb}), 32'({3'd3, 3'd3}));

        // Load then dependent store data: no stall, store-data forward next cycle.
        nops(3);
        step(3'd2, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd3, 5'd0, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0);
        check("dir_ls_nostall", 32'(s_pc), 32'd1);
        step(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("dir_ls_fwd", 32'(s_ls), 32'd1);

        // Multi-cycle op: two held cycles, one MC-use stall, then MEM forward.
        nops(3);
        step(3'd4, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 5'd11, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1);
        check("dir_mc_busy0", 32'({s_busy, s_em, s_fdf}), 32'b110);
        step(3'd1, 5'd11, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        check("dir_mc_busy1", 32'({s_busy, s_em}), 32'b11);
        step(3'd1, 5'd11, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        check("dir_mc_stall", 32'({s_busy, s_pc, s_def}), 32'b001);
        step(3'd1, 5'd11, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        check("dir_mc_fwd", 32'({s_fa, s_pc}), 32'({3'd2, 1'b1}));

        // x0 is never a hazard; a stall suppresses a coincident branch flush.
        nops(3);
        step(3'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("dir_x0", 32'({s_fa, s_fb, s_pc}), 32'({3'd0, 3'd0, 1'b1}));
        step(3'd2, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1);
        check("dir_br_stall", 32'({s_fdf, s_pc}), 32'b00);

        // Reset in the middle of a multi-cycle op.
        nops(3);
        step(3'd4, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("dir_pre_rst_busy", 32'(s_busy), 32'd1);
        apply_reset();
        step(3'd1, 5'd13, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0);
        check("dir_post_rst", 32'({s_fa, s_pc, s_busy}), 32'({3'd0, 1'b1, 1'b0}));

        // Random traffic on a small register set to provoke many hazards.
        for (int i = 0; i < 1500; i++) begin
            step(3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 2),
                 1'(($urandom % 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
